// File: rtl/dca_matrix_lsu_wdata_packer.sv
// Store-side write-data packer: queues store descriptors, pulls tensor rows and slices them
// into AXI W beats with tail strobes and WLAST on programmable burst boundaries.
module dca_matrix_lsu_wdata_packer #(
  parameter int unsigned BW_AXI_DATA    = 32,
  parameter int unsigned BW_TENSOR_ROW  = 128,
  parameter int unsigned TXN_FIFO_DEPTH = 4,
  parameter int unsigned BW_NUM_ROWS    = 16,
  localparam int unsigned AXI_BYTES     = BW_AXI_DATA / 8,
  localparam int unsigned ROW_BYTES     = BW_TENSOR_ROW / 8,
  localparam int unsigned BW_ROW_BYTES  = $clog2(ROW_BYTES + 1)
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     enable,
  output logic                     busy,
  output logic                     done,
  input  logic                     txn_valid,
  output logic                     txn_ready,
  input  logic [BW_NUM_ROWS-1:0]   txn_num_rows,
  input  logic [BW_ROW_BYTES-1:0]  txn_row_bytes,
  input  logic [7:0]               txn_awlen,
  input  logic                     row_valid,
  output logic                     row_ready,
  input  logic [BW_TENSOR_ROW-1:0] row_data,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [BW_AXI_DATA-1:0]   wdata,
  output logic [AXI_BYTES-1:0]     wstrb,
  output logic                     wlast
);

  localparam int unsigned NUM_BEATS = BW_TENSOR_ROW / BW_AXI_DATA;
  localparam int unsigned BW_BEAT   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned BW_PTR    = $clog2(TXN_FIFO_DEPTH);
  localparam int unsigned AXI_SHIFT = $clog2(AXI_BYTES);
  localparam int unsigned BW_TAIL   = AXI_SHIFT + 1;

  typedef enum logic [1:0] {StIdle, StRow, StBeat} state_e;

  typedef struct packed {
    logic [BW_NUM_ROWS-1:0]  num_rows;
    logic [BW_ROW_BYTES-1:0] row_bytes;
    logic [7:0]              awlen;
  } txn_t;

  txn_t                              fifo_mem [TXN_FIFO_DEPTH];
  logic [BW_PTR:0]                   wr_ptr_q, rd_ptr_q;
  logic                              fifo_empty, fifo_full, push, pop, ready_q;
  txn_t                              head;

  state_e                            state_q, state_d;
  logic [NUM_BEATS-1:0][BW_AXI_DATA-1:0] row_q;
  logic [BW_BEAT-1:0]                beat_idx_q, beat_idx_d;
  logic [BW_NUM_ROWS-1:0]            row_idx_q, row_idx_d;
  logic [7:0]                        burst_cnt_q, burst_cnt_d;
  logic [BW_NUM_ROWS-1:0]            num_rows_q;
  logic [BW_ROW_BYTES-1:0]           row_bytes_q;
  logic [7:0]                        awlen_q;
  logic                              done_q, done_d, load_row;

  logic [BW_ROW_BYTES-1:0]           eff_bytes, eff_m1;
  logic [BW_BEAT-1:0]                last_beat_idx;
  logic [BW_TAIL-1:0]                tail_bytes;
  logic [AXI_BYTES-1:0]              tail_strb;
  logic                              last_beat, last_row, final_beat;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[BW_PTR] != rd_ptr_q[BW_PTR]) &&
                      (wr_ptr_q[BW_PTR-1:0] == rd_ptr_q[BW_PTR-1:0]);
  assign txn_ready  = ready_q & ~fifo_full;
  assign push       = txn_valid & txn_ready;
  assign pop        = (state_q == StIdle) & enable & ~fifo_empty;
  assign head       = fifo_mem[rd_ptr_q[BW_PTR-1:0]];

  // A row_bytes of zero encodes a full row.
  assign eff_bytes     = (row_bytes_q == '0) ? BW_ROW_BYTES'(ROW_BYTES) : row_bytes_q;
  assign eff_m1        = eff_bytes - BW_ROW_BYTES'(1);
  assign last_beat_idx = BW_BEAT'(eff_m1 >> AXI_SHIFT);
  assign tail_bytes    = {1'b0, eff_m1[AXI_SHIFT-1:0]} + BW_TAIL'(1);

  always_comb begin
    tail_strb = '0;
    for (int i = 0; i < AXI_BYTES; i++) begin
      tail_strb[i] = (BW_TAIL'(i) < tail_bytes);
    end
  end

  assign last_beat  = (beat_idx_q == last_beat_idx);
  assign last_row   = (row_idx_q == (num_rows_q - BW_NUM_ROWS'(1)));
  assign final_beat = last_beat & last_row;

  assign wvalid = (state_q == StBeat);
  assign wlast  = wvalid & ((burst_cnt_q == awlen_q) | final_beat);
  assign wstrb  = wvalid ? (last_beat ? tail_strb : '1) : '0;
  assign wdata  = wvalid ? row_q[beat_idx_q] : '0;
  assign busy   = ~fifo_empty | (state_q != StIdle);
  assign done   = done_q;

  always_comb begin
    state_d     = state_q;
    beat_idx_d  = beat_idx_q;
    row_idx_d   = row_idx_q;
    burst_cnt_d = burst_cnt_q;
    done_d      = 1'b0;
    load_row    = 1'b0;
    row_ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          row_idx_d   = '0;
          burst_cnt_d = '0;
          beat_idx_d  = '0;
          if (head.num_rows == '0) done_d = 1'b1;
          else                     state_d = StRow;
        end
      end
      StRow: begin
        row_ready = enable;
        if (row_valid && enable) begin
          load_row   = 1'b1;
          beat_idx_d = '0;
          state_d    = StBeat;
        end
      end
      StBeat: begin
        // Accepting the next row on the final beat of a row avoids a bubble between rows.
        if (last_beat && !last_row) row_ready = enable & wready;
        if (wready) begin
          burst_cnt_d = wlast ? 8'd0 : burst_cnt_q + 8'd1;
          if (!last_beat) begin
            beat_idx_d = beat_idx_q + BW_BEAT'(1);
          end else if (last_row) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            row_idx_d = row_idx_q + BW_NUM_ROWS'(1);
            if (row_valid && enable) begin
              load_row   = 1'b1;
              beat_idx_d = '0;
            end else begin
              state_d = StRow;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      ready_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= StIdle;
      row_q       <= '0;
      beat_idx_q  <= '0;
      row_idx_q   <= '0;
      burst_cnt_q <= '0;
      num_rows_q  <= '0;
      row_bytes_q <= '0;
      awlen_q     <= '0;
      done_q      <= 1'b0;
    end else if (clear) begin
      ready_q     <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= StIdle;
      beat_idx_q  <= '0;
      row_idx_q   <= '0;
      burst_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      ready_q     <= 1'b1;
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      row_idx_q   <= row_idx_d;
      burst_cnt_q <= burst_cnt_d;
      done_q      <= done_d;
      if (push) begin
        fifo_mem[wr_ptr_q[BW_PTR-1:0]] <= '{num_rows: txn_num_rows, row_bytes: txn_row_bytes,
                                            awlen: txn_awlen};
        wr_ptr_q <= wr_ptr_q + (BW_PTR + 1)'(1);
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + (BW_PTR + 1)'(1);
        num_rows_q  <= head.num_rows;
        row_bytes_q <= head.row_bytes;
        awlen_q     <= head.awlen;
      end
      if (load_row) row_q <= row_data;
    end
  end

endmodule

// File: tb/tb_dca_matrix_lsu_wdata_packer.sv
// Directed bench for the W-data packer: row slicing, strobes, bursts, stalls, queueing and clear.
module tb_dca_matrix_lsu_wdata_packer;

  logic         clk, rstnn, clear, enable, busy, done;
  logic         txn_valid, txn_ready;
  logic [15:0]  txn_num_rows;
  logic [4:0]   txn_row_bytes;
  logic [7:0]   txn_awlen;
  logic         row_valid, row_ready;
  logic [127:0] row_data;
  logic         wvalid, wready, wlast;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;

  int total = 0;
  int bad   = 0;

  logic [31:0] beat_data [64];
  logic [3:0]  beat_strb [64];
  logic        beat_last [64];
  int nbeats, ndone, done_cyc, last_beat_cyc, gaps, stall_viol, stall_cycles, wvalid_cycles;
  logic busy_at_done;
  int row_seq;

  dca_matrix_lsu_wdata_packer dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable), .busy(busy), .done(done),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_num_rows(txn_num_rows),
    .txn_row_bytes(txn_row_bytes), .txn_awlen(txn_awlen),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Row k carries byte b = {k[3:0], b[3:0]}.
  function automatic logic [127:0] mk_row(input int k);
    logic [127:0] r;
    logic [3:0] kk;
    kk = k[3:0];
    for (int b = 0; b < 16; b++) r[8*b +: 8] = {kk, 4'(b)};
    return r;
  endfunction

  function automatic logic [31:0] exp_word(input int k, input int j);
    logic [3:0] kk;
    logic [3:0] b0;
    kk = k[3:0];
    b0 = 4'(4 * j);
    return {kk, b0 + 4'd3, kk, b0 + 4'd2, kk, b0 + 4'd1, kk, b0};
  endfunction

  task automatic restart_rows();
    row_seq  = 0;
    row_data = mk_row(0);
  endtask

  task automatic push(input int n, input int rb, input int al);
    int w;
    w = 0;
    txn_valid     = 1'b1;
    txn_num_rows  = 16'(n);
    txn_row_bytes = 5'(rb);
    txn_awlen     = 8'(al);
    @(negedge clk);
    while (txn_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (w >= 20) begin
      bad++;
      $display("FAIL push_timeout txn_ready=%b required=1", txn_ready);
    end
    @(posedge clk);
    #1;
    txn_valid = 1'b0;
  endtask

  // Drives wready and records W beats / done pulses until the requested number of done pulses,
  // stop_beats beats (if nonzero), or the cycle budget.
  task automatic collect(input int want_done, input int stop_beats, input int stall_at,
                         input int stall_len, input int max_cyc);
    int cyc;
    logic [31:0] snap_d;
    logic [3:0]  snap_s;
    logic        snap_l, rowhs;
    nbeats = 0; ndone = 0; done_cyc = -1; last_beat_cyc = -1; gaps = 0;
    stall_viol = 0; stall_cycles = 0; wvalid_cycles = 0; busy_at_done = 1'b0;
    snap_d = '0; snap_s = '0; snap_l = 1'b0;
    cyc = 0;
    while (cyc < max_cyc && ndone < want_done && (stop_beats == 0 || nbeats < stop_beats)) begin
      wready = 1'b1;
      if (wvalid && (nbeats + 1 == stall_at) && stall_cycles < stall_len) wready = 1'b0;
      @(negedge clk);
      if (wvalid) wvalid_cycles++;
      if (wvalid && !wready) begin
        if (stall_cycles == 0) begin
          snap_d = wdata; snap_s = wstrb; snap_l = wlast;
        end else if (wdata !== snap_d || wstrb !== snap_s || wlast !== snap_l) begin
          stall_viol++;
        end
        if (row_ready !== 1'b0) stall_viol++;
        stall_cycles++;
      end
      if (wvalid && wready) begin
        if (stall_cycles > 0 && nbeats + 1 == stall_at &&
            (wdata !== snap_d || wstrb !== snap_s || wlast !== snap_l)) stall_viol++;
        if (last_beat_cyc >= 0 && cyc != last_beat_cyc + 1) gaps++;
        if (nbeats < 64) begin
          beat_data[nbeats] = wdata;
          beat_strb[nbeats] = wstrb;
          beat_last[nbeats] = wlast;
        end
        nbeats++;
        last_beat_cyc = cyc;
      end
      if (done === 1'b1) begin
        ndone++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      rowhs = row_valid & row_ready;
      @(posedge clk);
      #1;
      if (rowhs) begin
        row_seq++;
        row_data = mk_row(row_seq);
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    rstnn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({wvalid, wlast, done, busy, row_ready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl wvalid/wlast/done/busy/row_ready=%b required=00000",
               {wvalid, wlast, done, busy, row_ready});
    end
    total++;
    if (wdata !== 32'h0 || wstrb !== 4'h0) begin
      bad++;
      $display("FAIL reset_data wdata=%h wstrb=%h required=0/0", wdata, wstrb);
    end
    total++;
    if (txn_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_txn_ready got=%b required=0", txn_ready);
    end
    @(posedge clk);
    #1;
    rstnn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (txn_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset txn_ready=%b busy=%b required=1/0", txn_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_rows();
    restart_rows();
    push(2, 16, 7);
    collect(1, 0, 0, 0, 60);
    total++;
    if (nbeats !== 8) begin bad++; $display("FAIL t1_nbeats got=%0d required=8", nbeats); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({beat_data[i], beat_strb[i], beat_last[i]} !== {exp_word(i / 4, i % 4), 4'hF, i == 7})
      begin
        bad++;
        $display("FAIL t1_beat%0d got=%h/%h/%b required=%h/f/%b", i, beat_data[i], beat_strb[i],
                 beat_last[i], exp_word(i / 4, i % 4), i == 7);
      end
    end
    total++;
    if (gaps !== 0) begin bad++; $display("FAIL t1_bubbles got=%0d required=0", gaps); end
    total++;
    if (ndone !== 1 || done_cyc !== last_beat_cyc + 1 || busy_at_done !== 1'b0) begin
      bad++;
      $display("FAIL t1_done count=%0d cyc=%0d last=%0d busy=%b required=1/last+1/0",
               ndone, done_cyc, last_beat_cyc, busy_at_done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL t1_done_width got=%b required=0", done); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_partial_row();
    logic [3:0] es [3];
    es = '{4'hF, 4'hF, 4'h3};
    restart_rows();
    push(1, 10, 15);
    collect(1, 0, 0, 0, 40);
    total++;
    if (nbeats !== 3 || ndone !== 1) begin
      bad++;
      $display("FAIL t2_counts beats=%0d done=%0d required=3/1", nbeats, ndone);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({beat_data[i], beat_strb[i], beat_last[i]} !== {exp_word(0, i), es[i], i == 2}) begin
        bad++;
        $display("FAIL t2_beat%0d got=%h/%h/%b required=%h/%h/%b", i, beat_data[i],
                 beat_strb[i], beat_last[i], exp_word(0, i), es[i], i == 2);
      end
    end
  endtask

  task automatic test_bursts();
    restart_rows();
    push(3, 16, 3);
    collect(1, 0, 0, 0, 80);
    total++;
    if (nbeats !== 12 || ndone !== 1) begin
      bad++;
      $display("FAIL t3_counts beats=%0d done=%0d required=12/1", nbeats, ndone);
    end
    for (int i = 0; i < 12; i++) begin
      total++;
      if ({beat_data[i], beat_last[i]} !== {exp_word(i / 4, i % 4), (i % 4) == 3}) begin
        bad++;
        $display("FAIL t3_beat%0d got=%h/%b required=%h/%b", i, beat_data[i], beat_last[i],
                 exp_word(i / 4, i % 4), (i % 4) == 3);
      end
    end
  endtask

  task automatic test_stall();
    restart_rows();
    push(2, 16, 7);
    collect(1, 0, 2, 5, 80);
    total++;
    if (stall_cycles !== 5 || stall_viol !== 0) begin
      bad++;
      $display("FAIL t4_stall cycles=%0d violations=%0d required=5/0", stall_cycles, stall_viol);
    end
    total++;
    if (nbeats !== 8 || ndone !== 1) begin
      bad++;
      $display("FAIL t4_counts beats=%0d done=%0d required=8/1", nbeats, ndone);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({beat_data[i], beat_strb[i], beat_last[i]} !== {exp_word(i / 4, i % 4), 4'hF, i == 7})
      begin
        bad++;
        $display("FAIL t4_beat%0d got=%h/%h/%b required=%h/f/%b", i, beat_data[i], beat_strb[i],
                 beat_last[i], exp_word(i / 4, i % 4), i == 7);
      end
    end
  endtask

  task automatic test_queue();
    int bp [4];
    logic [3:0] ls [4];
    int idx;
    bp = '{1, 2, 3, 4};
    ls = '{4'hF, 4'h1, 4'hF, 4'hF};
    restart_rows();
    enable = 1'b0;
    push(1, 4, 15);
    push(1, 5, 15);
    push(1, 12, 15);
    push(1, 0, 15);
    @(negedge clk);
    total++;
    if (txn_ready !== 1'b0 || busy !== 1'b1 || wvalid !== 1'b0) begin
      bad++;
      $display("FAIL t5_full txn_ready=%b busy=%b wvalid=%b required=0/1/0",
               txn_ready, busy, wvalid);
    end
    @(posedge clk);
    #1;
    enable = 1'b1;
    collect(4, 0, 0, 0, 200);
    total++;
    if (nbeats !== 10 || ndone !== 4) begin
      bad++;
      $display("FAIL t5_counts beats=%0d done=%0d required=10/4", nbeats, ndone);
    end
    idx = 0;
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < bp[t]; j++) begin
        total++;
        if ({beat_data[idx], beat_strb[idx], beat_last[idx]} !==
            {exp_word(t, j), (j == bp[t] - 1) ? ls[t] : 4'hF, j == bp[t] - 1}) begin
          bad++;
          $display("FAIL t5_txn%0d_beat%0d got=%h/%h/%b required=%h/%h/%b", t, j,
                   beat_data[idx], beat_strb[idx], beat_last[idx], exp_word(t, j),
                   (j == bp[t] - 1) ? ls[t] : 4'hF, j == bp[t] - 1);
        end
        idx++;
      end
    end
    @(negedge clk);
    total++;
    if (txn_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t5_drained txn_ready=%b busy=%b required=1/0", txn_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_and_clear();
    int spur;
    restart_rows();
    push(0, 16, 7);
    collect(1, 0, 0, 0, 20);
    total++;
    if (ndone !== 1 || wvalid_cycles !== 0) begin
      bad++;
      $display("FAIL t6_zero_rows done=%0d wvalid_cycles=%0d required=1/0", ndone, wvalid_cycles);
    end
    restart_rows();
    push(2, 16, 7);
    collect(1, 2, 0, 0, 40);
    total++;
    if (nbeats !== 2 || ndone !== 0) begin
      bad++;
      $display("FAIL t6_pre_clear beats=%0d done=%0d required=2/0", nbeats, ndone);
    end
    clear = 1'b1;
    @(negedge clk);
    total++;
    if (wvalid !== 1'b1 || wdata !== exp_word(0, 2)) begin
      bad++;
      $display("FAIL t6_beat3 wvalid=%b wdata=%h required=1/%h", wvalid, wdata, exp_word(0, 2));
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    total++;
    if (wvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || txn_ready !== 1'b1) begin
      bad++;
      $display("FAIL t6_after_clear wvalid=%b busy=%b done=%b txn_ready=%b required=0/0/0/1",
               wvalid, busy, done, txn_ready);
    end
    spur = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wvalid || done) spur++;
    end
    total++;
    if (spur !== 0) begin bad++; $display("FAIL t6_quiet spurious=%0d required=0", spur); end
    @(posedge clk);
    #1;
    restart_rows();
    push(1, 16, 15);
    collect(1, 0, 0, 0, 30);
    total++;
    if (nbeats !== 4 || ndone !== 1) begin
      bad++;
      $display("FAIL t6_post_counts beats=%0d done=%0d required=4/1", nbeats, ndone);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({beat_data[i], beat_strb[i], beat_last[i]} !== {exp_word(0, i), 4'hF, i == 3}) begin
        bad++;
        $display("FAIL t6_post_beat%0d got=%h/%h/%b required=%h/f/%b", i, beat_data[i],
                 beat_strb[i], beat_last[i], exp_word(0, i), i == 3);
      end
    end
  endtask

  initial begin
    rstnn         = 1'b0;
    clear         = 1'b0;
    enable        = 1'b1;
    txn_valid     = 1'b0;
    txn_num_rows  = '0;
    txn_row_bytes = '0;
    txn_awlen     = '0;
    row_valid     = 1'b1;
    wready        = 1'b1;
    restart_rows();
    test_reset();
    test_full_rows();
    test_partial_row();
    test_bursts();
    test_stall();
    test_queue();
    test_zero_and_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
